// File: rtl/shufflev_perm_gen.sv
// rtl/shufflev_perm_gen.sv - Fisher-Yates permutation builder fed by the shufflev RNG stream
// Rejection sampling keeps each draw uniform over [0,i] for any slot count.
module shufflev_perm_gen #(
    parameter int  NumSlots = 4,
    parameter int  RngWidth = 3,
    localparam int IdxW     = $clog2(NumSlots)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [RngWidth-1:0]      rng_number_i,
    input  logic                     rng_valid_i,
    input  logic                     shuffle_en_i,
    output logic [NumSlots*IdxW-1:0] perm_o,
    output logic                     perm_valid_o,
    input  logic                     perm_ready_i,
    output logic [7:0]               draw_cnt_o
);

    localparam logic [0:0]      StShuffle = 1'b0;
    localparam logic [0:0]      StDone    = 1'b1;
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumSlots - 1);

    logic [0:0]      state_q;
    logic [IdxW-1:0] idx_q;
    logic [7:0]      draw_cnt_q;
    logic [IdxW-1:0] perm_q [NumSlots];
    logic [IdxW-1:0] mask;
    logic [IdxW-1:0] draw_j;
    logic            accept;
    logic            bypass;

    // Mask covers exactly $clog2(i+1) low bits: every bit up to the MSB of i.
    always_comb begin
        mask = '0;
        for (int k = 0; k < IdxW; k++) begin
            if ((idx_q >> k) != '0) begin
                mask[k] = 1'b1;
            end
        end
    end

    assign draw_j = rng_number_i[IdxW-1:0] & mask;
    assign accept = (draw_j <= idx_q);
    // Bypass is only honoured before the first draw of a permutation.
    assign bypass = !shuffle_en_i && (idx_q == LastIdx) && (draw_cnt_q == 8'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StShuffle;
            idx_q      <= LastIdx;
            draw_cnt_q <= 8'd0;
            for (int k = 0; k < NumSlots; k++) begin
                perm_q[k] <= IdxW'(k);
            end
        end else begin
            case (state_q)
                StShuffle: begin
                    if (bypass) begin
                        draw_cnt_q <= 8'd0;
                        state_q    <= StDone;
                        for (int k = 0; k < NumSlots; k++) begin
                            perm_q[k] <= IdxW'(k);
                        end
                    end else if (rng_valid_i) begin
                        if (draw_cnt_q != 8'hFF) begin
                            draw_cnt_q <= draw_cnt_q + 8'd1;
                        end
                        if (accept) begin
                            perm_q[idx_q]  <= perm_q[draw_j];
                            perm_q[draw_j] <= perm_q[idx_q];
                            if (idx_q == IdxW'(1)) begin
                                state_q <= StDone;
                            end else begin
                                idx_q <= idx_q - IdxW'(1);
                            end
                        end
                    end
                end
                StDone: begin
                    if (perm_ready_i) begin
                        state_q    <= StShuffle;
                        idx_q      <= LastIdx;
                        draw_cnt_q <= 8'd0;
                        for (int k = 0; k < NumSlots; k++) begin
                            perm_q[k] <= IdxW'(k);
                        end
                    end
                end
                default: state_q <= StShuffle;
            endcase
        end
    end

    always_comb begin
        perm_o = '0;
        for (int k = 0; k < NumSlots; k++) begin
            perm_o[k*IdxW +: IdxW] = perm_q[k];
        end
    end

    assign perm_valid_o = (state_q == StDone);
    assign draw_cnt_o   = draw_cnt_q;

endmodule
